pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl_if.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush controller bus: hazard requests in, stall vector / flush / statistics out.
// master = pipeline side driving requests, slave = the controller.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_i_stallreq;
  logic             ex_i_div_start;
  logic             ex_i_div_ready;
  logic             mem_i_dreq;
  logic             mem_i_dack;
  logic             excp_i_valid;
  logic [31:0]      excp_i_pc;
  logic [5:0]       stop;
  logic             flush;
  logic [31:0]      flush_pc;
  logic             div_cancel;
  logic [CNT_W-1:0] stall_cycles;
  logic             stall_timeout;

  modport master (
    output id_i_stallreq, ex_i_div_start, ex_i_div_ready, mem_i_dreq, mem_i_dack,
           excp_i_valid, excp_i_pc,
    input  stop, flush, flush_pc, div_cancel, stall_cycles, stall_timeout
  );

  modport slave (
    input  id_i_stallreq, ex_i_div_start, ex_i_div_ready, mem_i_dreq, mem_i_dack,
           excp_i_valid, excp_i_pc,
    output stop, flush, flush_pc, div_cancel, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: stop vector is combinational in the request cycle,
// flush/div_cancel/statistics are registered one edge later; exceptions override every stall.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input logic              cpu_clk,
  input logic              cpu_rst_n,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [5:0]       STOP_MEM = 6'b011111;
  localparam logic [5:0]       STOP_EX  = 6'b001111;
  localparam logic [5:0]       STOP_ID  = 6'b000111;
  localparam logic [5:0]       NOSTOP   = 6'b000000;
  localparam logic [15:0]      WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic             div_pend;
  logic             mem_req;
  logic             div_req;
  logic             stalled;
  logic [5:0]       stop_vec;
  logic             flush_q;
  logic [31:0]      flush_pc_q;
  logic             div_cancel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      wd_q;
  logic             timeout_q;

  // Requests that do not complete in the cycle they are issued.
  assign mem_req = bus.mem_i_dreq && !bus.mem_i_dack;
  assign div_req = bus.ex_i_div_start && !bus.ex_i_div_ready;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.excp_i_valid) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        RUN: begin
          if (mem_req) begin
            state_nxt = MEM_WAIT;
          end else if (div_req) begin
            state_nxt = DIV_WAIT;
          end
        end
        DIV_WAIT: begin
          if (bus.ex_i_div_ready) begin
            state_nxt = RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_i_dack) begin
            state_nxt = (div_pend && !bus.ex_i_div_ready) ? DIV_WAIT : RUN;
          end
        end
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Stop vector gated by reset so it drops the instant reset asserts.
  always_comb begin
    stop_vec = NOSTOP;
    if (cpu_rst_n && !bus.excp_i_valid && state != FLUSH) begin
      if ((state == MEM_WAIT && !bus.mem_i_dack) || mem_req) begin
        stop_vec = STOP_MEM;
      end else if ((state == DIV_WAIT && !bus.ex_i_div_ready) || div_req) begin
        stop_vec = STOP_EX;
      end else if (bus.id_i_stallreq) begin
        stop_vec = STOP_ID;
      end
    end
  end

  assign stalled = |stop_vec;

  // A divider launched behind a memory wait is parked here until the wait ends.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      div_pend <= 1'b0;
    end else if (bus.excp_i_valid || state == FLUSH) begin
      div_pend <= 1'b0;
    end else if (state_nxt == MEM_WAIT && div_req) begin
      div_pend <= 1'b1;
    end else if (bus.ex_i_div_ready || state_nxt != MEM_WAIT) begin
      div_pend <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      flush_q      <= 1'b0;
      flush_pc_q   <= 32'h0000_0000;
      div_cancel_q <= 1'b0;
    end else begin
      flush_q      <= bus.excp_i_valid;
      div_cancel_q <= bus.excp_i_valid && (state == DIV_WAIT || div_pend);
      if (bus.excp_i_valid) begin
        flush_pc_q <= bus.excp_i_pc;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_q     <= '0;
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (stalled && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (stalled) begin
        if (wd_q != WD_LAST) begin
          wd_q <= wd_q + 16'd1;
        end
        if (wd_q == WD_LAST) begin
          timeout_q <= 1'b1;
        end
      end else begin
        wd_q <= 16'd0;
      end
    end
  end

  assign bus.stop          = stop_vec;
  assign bus.flush         = flush_q;
  assign bus.flush_pc      = flush_pc_q;
  assign bus.div_cancel    = div_cancel_q;
  assign bus.stall_cycles  = cnt_q;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus constrained-random traffic against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) dif ();

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .bus       (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: outstanding memory access, outstanding division, flush cycle.
  bit          m_mem, m_div, m_fl;
  bit          m_flush, m_cancel, m_to;
  logic [31:0] m_pc;
  int          m_cycles, m_wd;

  logic [5:0]       exp_stop, act_stop;
  logic             act_flush, act_cancel, act_to;
  logic [31:0]      act_pc;
  logic [CNT_W-1:0] act_cycles;

  task automatic do_reset();
    rst_n = 1'b0;
    dif.id_i_stallreq = 0; dif.ex_i_div_start = 0; dif.ex_i_div_ready = 0;
    dif.mem_i_dreq = 0; dif.mem_i_dack = 0; dif.excp_i_valid = 0; dif.excp_i_pc = '0;
    m_mem = 0; m_div = 0; m_fl = 0; m_flush = 0; m_cancel = 0; m_to = 0;
    m_pc = '0; m_cycles = 0; m_wd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; records the model's expectation and the DUT's outputs.
  task automatic cyc(input bit id, input bit st, input bit rd, input bit dq,
                     input bit dk, input bit ex, input logic [31:0] pc);
    int k;
    bit old_div;
    @(negedge clk);
    dif.id_i_stallreq = id; dif.ex_i_div_start = st; dif.ex_i_div_ready = rd;
    dif.mem_i_dreq = dq; dif.mem_i_dack = dk; dif.excp_i_valid = ex; dif.excp_i_pc = pc;
    #1;
    k = -1;
    if (!(ex || m_fl)) begin
      if ((m_mem && !dk) || (dq && !dk)) k = 4;
      else if ((m_div && !m_mem && !rd) || (st && !rd)) k = 3;
      else if (id) k = 2;
    end
    exp_stop = (k < 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
    act_stop = dif.stop;
    old_div = m_div;
    @(posedge clk);
    if (exp_stop != 0) begin
      m_cycles = (m_cycles < CNT_MAX) ? m_cycles + 1 : CNT_MAX;
      m_wd++;
      if (m_wd >= TIMEOUT) m_to = 1;
    end else begin
      m_wd = 0;
    end
    m_flush  = ex;
    m_cancel = ex && old_div;
    if (ex) m_pc = pc;
    if (ex) begin
      m_mem = 0; m_div = 0; m_fl = 1;
    end else if (m_fl) begin
      m_fl = 0;
    end else begin
      if (m_mem) begin
        if (dk) m_mem = 0;
      end else if (dq && !dk) begin
        m_mem = 1;
      end
      if (rd) m_div = 0;
      else if (st) m_div = 1;
    end
    #1;
    act_flush = dif.flush; act_pc = dif.flush_pc; act_cancel = dif.div_cancel;
    act_cycles = dif.stall_cycles; act_to = dif.stall_timeout;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dif.stop !== 6'b0) begin failures++; $display("FAIL reset_stop got=%b exp=000000", dif.stop); end
    checks++; if (dif.flush !== 1'b0 || dif.div_cancel !== 1'b0 || dif.stall_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_flags got flush=%b cancel=%b timeout=%b exp=0", dif.flush, dif.div_cancel, dif.stall_timeout); end
    checks++; if (dif.flush_pc !== 32'h0) begin failures++; $display("FAIL reset_flush_pc got=%h exp=0", dif.flush_pc); end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 32'h0);
      checks++; if (act_stop !== 6'b0) begin failures++; $display("FAIL idle_stop cyc%0d got=%b exp=000000", i, act_stop); end
    end
    checks++; if (act_flush !== 1'b0 || act_cycles !== 4'd0) begin
      failures++; $display("FAIL idle_state got flush=%b cycles=%0d exp flush=0 cycles=0", act_flush, act_cycles); end
  endtask

  task automatic test_id_stall();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b000111) begin failures++; $display("FAIL id_stop got=%b exp=000111", act_stop); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b0) begin failures++; $display("FAIL id_release got=%b exp=000000", act_stop); end
    checks++; if (act_cycles !== 4'd1) begin failures++; $display("FAIL id_cycles got=%0d exp=1", act_cycles); end
  endtask

  task automatic test_div_stall();
    bit [5:0] want;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      cyc(0, c == 5, c == 10, 0, 0, 0, 32'h0);
      want = (c >= 5 && c <= 9) ? 6'b001111 : 6'b000000;
      checks++; if (act_stop !== want) begin failures++; $display("FAIL div_stop cyc%0d got=%b exp=%b", c, act_stop, want); end
    end
    checks++; if (act_cycles !== 4'd5) begin failures++; $display("FAIL div_cycles got=%0d exp=5", act_cycles); end
  endtask

  task automatic test_mem_over_id();
    bit [5:0] want;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      cyc(c < 3, 0, 0, c == 0, c == 3, 0, 32'h0);
      want = (c < 3) ? 6'b011111 : 6'b000000;
      checks++; if (act_stop !== want) begin failures++; $display("FAIL mem_stop cyc%0d got=%b exp=%b", c, act_stop, want); end
    end
  endtask

  task automatic test_div_pend();
    bit [5:0] tbl [5] = '{6'b011111, 6'b011111, 6'b000000, 6'b001111, 6'b000000};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cyc(0, c == 0, c == 4, c == 0, c == 2, 0, 32'h0);
      checks++; if (act_stop !== tbl[c]) begin failures++; $display("FAIL pend_stop cyc%0d got=%b exp=%b", c, act_stop, tbl[c]); end
    end
  endtask

  task automatic test_single_cycle();
    do_reset();
    cyc(0, 1, 1, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b0) begin failures++; $display("FAIL quick_div got=%b exp=000000", act_stop); end
    cyc(0, 0, 0, 1, 1, 0, 32'h0);
    checks++; if (act_stop !== 6'b0) begin failures++; $display("FAIL quick_mem got=%b exp=000000", act_stop); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b0 || act_cycles !== 4'd0) begin
      failures++; $display("FAIL quick_after got stop=%b cycles=%0d exp stop=000000 cycles=0", act_stop, act_cycles); end
  endtask

  task automatic test_exception();
    do_reset();
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b001111) begin failures++; $display("FAIL excp_divwait got=%b exp=001111", act_stop); end
    cyc(1, 0, 0, 1, 0, 1, 32'hBFC0_0380);
    checks++; if (act_stop !== 6'b0) begin failures++; $display("FAIL excp_stop got=%b exp=000000", act_stop); end
    checks++; if (act_flush !== 1'b1 || act_pc !== 32'hBFC0_0380 || act_cancel !== 1'b1) begin
      failures++; $display("FAIL excp_flush got flush=%b pc=%h cancel=%b exp 1 bfc00380 1", act_flush, act_pc, act_cancel); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b0 || act_flush !== 1'b0 || act_cancel !== 1'b0) begin
      failures++; $display("FAIL excp_end got stop=%b flush=%b cancel=%b exp 000000 0 0", act_stop, act_flush, act_cancel); end
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b000111) begin failures++; $display("FAIL excp_run got=%b exp=000111", act_stop); end
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0180);
    cyc(0, 0, 0, 1, 0, 1, 32'hBFC0_0200);
    checks++; if (act_stop !== 6'b0 || act_flush !== 1'b1 || act_pc !== 32'hBFC0_0200 || act_cancel !== 1'b0) begin
      failures++; $display("FAIL rearm got stop=%b flush=%b pc=%h cancel=%b exp 000000 1 bfc00200 0", act_stop, act_flush, act_pc, act_cancel); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b0 || act_flush !== 1'b0) begin
      failures++; $display("FAIL rearm_end got stop=%b flush=%b exp 000000 0", act_stop, act_flush); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, i == 0, 0, 0, 32'h0);
      checks++; if (act_to !== (i >= 3)) begin failures++; $display("FAIL wd_set cyc%0d got=%b exp=%b", i, act_to, i >= 3); end
    end
    cyc(0, 0, 0, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b0 || act_to !== 1'b1) begin
      failures++; $display("FAIL wd_sticky got stop=%b timeout=%b exp 000000 1", act_stop, act_to); end
    do_reset();
    checks++; if (dif.stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_reset got=%b exp=0", dif.stall_timeout); end
    for (int i = 0; i < 7; i++) cyc(i != 3, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_to !== 1'b0 || act_cycles !== 4'd6) begin
      failures++; $display("FAIL wd_clear got timeout=%b cycles=%0d exp 0 6", act_to, act_cycles); end
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (act_cycles !== 4'hF) begin failures++; $display("FAIL cnt_sat got=%0d exp=15", act_cycles); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cyc(0, 1, 0, 1, 0, 0, 32'h0);
    checks++; if (act_stop !== 6'b011111) begin failures++; $display("FAIL mid_before got=%b exp=011111", act_stop); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dif.stop !== 6'b0 || dif.stall_cycles !== 4'd0) begin
      failures++; $display("FAIL mid_async got stop=%b cycles=%0d exp 000000 0", dif.stop, dif.stall_cycles); end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 32'h0);
      checks++; if (act_stop !== 6'b0) begin failures++; $display("FAIL mid_pend cyc%0d got=%b exp=000000", i, act_stop); end
    end
  endtask

  task automatic test_random();
    bit id, st, rd, dq, dk, ex;
    logic [31:0] pc;
    for (int n = 0; n < 500; n++) begin
      if (n % 100 == 0) do_reset();
      id = 0; st = 0; rd = 0; dq = 0; dk = 0;
      ex = ($urandom % 12) == 0;
      pc = $urandom;
      if (!m_fl) begin
        id = ($urandom % 3) == 0;
        if (!m_mem && !m_div) begin
          dq = ($urandom % 4) == 0;
          dk = dq && (($urandom % 2) != 0);
          st = ($urandom % 4) == 0;
          rd = st && (($urandom % 3) == 0);
        end else begin
          if (m_mem) dk = ($urandom % 3) == 0;
          if (m_div) rd = ($urandom % 3) == 0;
        end
      end
      cyc(id, st, rd, dq, dk, ex, pc);
      checks++; if (act_stop !== exp_stop) begin failures++; $display("FAIL rnd_stop n=%0d got=%b exp=%b", n, act_stop, exp_stop); end
      checks++; if (act_flush !== m_flush || act_cancel !== m_cancel) begin
        failures++; $display("FAIL rnd_flush n=%0d got flush=%b cancel=%b exp %b %b", n, act_flush, act_cancel, m_flush, m_cancel); end
      checks++; if (act_pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, act_pc, m_pc); end
      checks++; if (act_cycles !== CNT_W'(m_cycles) || act_to !== m_to) begin
        failures++; $display("FAIL rnd_stats n=%0d got cycles=%0d timeout=%b exp %0d %b", n, act_cycles, act_to, m_cycles, m_to); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_id_stall();
    test_div_stall();
    test_mem_over_id();
    test_div_pend();
    test_single_cycle();
    test_exception();
    test_timeout();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
